w0rm_core_ifetch_queue: RTL and testbench

Parametrised, decoupled instruction-fetch stage for the W0RM core. It issues sequential fetch requests to instruction memory with a bounded number of requests in flight, and buffers returned instructions with their addresses in a DEPTH-entry queue. It presents them to decode over a valid/ready handshake. A branch redirect flushes the queue and discards stale in-flight responses. It sits between the instruction memory port and the decode stage.

---
 rtl/w0rm_core_ifetch_queue.sv | 113 +++++++++++
 tb/tb_w0rm_core_ifetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_core_ifetch_queue.sv
// rtl/w0rm_core_ifetch_queue.sv - decoupled instruction fetch with bounded in-flight requests
// and an instruction queue feeding decode; branch redirects flush and drop stale responses.
module w0rm_core_ifetch_queue #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INST_WIDTH      = 16,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PC_STEP         = 2,
    parameter logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(32'h2000_0000)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       mem_req_valid,
    output logic [ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic                       mem_req_ready,
    input  logic                       mem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      mem_rsp_data,
    output logic                       dec_valid,
    output logic [INST_WIDTH-1:0]      dec_inst,
    output logic [ADDR_WIDTH-1:0]      dec_addr,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     queue_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [INST_WIDTH-1:0] q_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop;
    logic [ADDR_WIDTH-1:0] tag_addr [MAX_OUTSTANDING];
    logic [TW-1:0]         tag_wr;
    logic [TW-1:0]         tag_rd;

    logic [CW:0] in_use;
    logic        accept;
    logic        rsp_keep;
    logic        pop;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Credit covers queued entries plus live in-flight requests; dropped ones never land.
    assign in_use = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop};

    assign mem_req_valid = ~reset & ~redirect_valid
                         & (outstanding < CW'(MAX_OUTSTANDING))
                         & (in_use < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid & mem_req_ready;
    assign rsp_keep      = mem_rsp_valid & (drop == '0) & ~redirect_valid;
    assign pop           = (count != '0) & dec_ready;

    assign dec_valid   = (count != '0);
    assign dec_inst    = dec_valid ? q_inst[rd_ptr] : '0;
    assign dec_addr    = dec_valid ? q_addr[rd_ptr] : '0;
    assign queue_count = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= START_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(mem_rsp_valid);
            if (accept)
                tag_wr <= tag_next(tag_wr);
            // Tags of dropped requests are still retired so the FIFO stays aligned.
            if (mem_rsp_valid)
                tag_rd <= tag_next(tag_rd);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                drop     <= outstanding - CW'(mem_rsp_valid);
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
                if (mem_rsp_valid && (drop != '0))
                    drop <= drop - CW'(1);
                if (rsp_keep)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_addr[tag_wr] <= fetch_pc;
        if (!reset && rsp_keep) begin
            q_inst[wr_ptr] <= mem_rsp_data;
            q_addr[wr_ptr] <= tag_addr[tag_rd];
        end
    end

endmodule

// File: tb/tb_w0rm_core_ifetch_queue.sv
// tb/tb_w0rm_core_ifetch_queue.sv - directed bench with a latency-modelled memory
// and an address/instruction scoreboard for the fetch queue.
module tb_w0rm_core_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] START = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        dec_valid;
    logic [15:0] dec_inst;
    logic [31:0] dec_addr;
    logic        dec_ready;
    logic [2:0]  queue_count;

    w0rm_core_ifetch_queue #(
        .ADDR_WIDTH(32), .INST_WIDTH(16), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
        .PC_STEP(2), .START_PC(START)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_addr(dec_addr), .dec_ready(dec_ready),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
    typedef struct { logic [31:0] addr; logic [15:0] inst; } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          passes = 0;
    int          total = 0;
    int          pop_cnt = 0;
    int          acc_cnt = 0;
    bit          rand_ready = 0;
    logic [31:0] model_pc = START;

    function automatic logic [15:0] inst_of(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        int          nonstale;
        bit          acc;
        bit          pp;
        logic [31:0] raddr;
        pend_t       p;
        if (reset || pend.size() == 0 || pend[0].due > cyc) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end else begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = inst_of(pend[0].addr);
        end
        if (rand_ready) mem_req_ready = 1'($urandom_range(0, 1));
        #4;
        nonstale = 0;
        foreach (pend[i]) if (!pend[i].stale) nonstale++;
        if (reset) begin
            chk("req_valid_in_reset", mem_req_valid, 0);
        end else begin
            chk("req_valid", mem_req_valid,
                !redirect_valid && pend.size() < MAXO && (sb.size() + nonstale < DEPTH));
            chk("queue_count", queue_count, sb.size());
            chk("dec_valid", dec_valid, sb.size() != 0);
        end
        raddr = mem_req_addr;
        acc = mem_req_valid && mem_req_ready && !reset;
        if (acc) chk("req_addr", raddr, model_pc);
        pp = dec_valid && dec_ready && !redirect_valid && !reset;
        if (pp && sb.size() > 0) begin
            chk("dec_addr", dec_addr, sb[0].addr);
            chk("dec_inst", dec_inst, sb[0].inst);
        end
        @(posedge clk);
        if (reset) begin
            pend.delete();
            sb.delete();
            model_pc = START;
        end else begin
            if (pp && sb.size() > 0) begin
                pop_log.push_back(sb[0].addr);
                void'(sb.pop_front());
                pop_cnt++;
            end
            if (redirect_valid) foreach (pend[i]) pend[i].stale = 1;
            if (mem_rsp_valid) begin
                p = pend.pop_front();
                if (!p.stale) sb.push_back('{p.addr, inst_of(p.addr)});
            end
            if (redirect_valid) sb.delete();
            if (acc) begin
                pend.push_back('{raddr, cyc + lat, 1'b0});
                acc_log.push_back(raddr);
                acc_cnt++;
                model_pc = model_pc + 32'd2;
            end
            if (redirect_valid) model_pc = redirect_pc;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int a0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; dec_ready = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_queue_count", queue_count, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_inst", dec_inst, 0);
        chk("rst_dec_addr", dec_addr, 0);
        chk("rst_req_addr", mem_req_addr, START);
        chk("first_req_valid", mem_req_valid, 1);

        // Streaming with single-cycle memory: one instruction per cycle once filled.
        lat = 1;
        repeat (8) step();
        pop_cnt = 0;
        repeat (16) step();
        chk("throughput", pop_cnt, 16);

        // Decode stalled: queue fills to DEPTH and fetch stops.
        do_reset();
        dec_ready = 1'b0;
        acc_log.delete();
        acc_cnt = 0;
        repeat (12) step();
        chk("accepts_when_stalled", acc_cnt, 4);
        chk("full_count", queue_count, 4);
        chk("full_req_valid", mem_req_valid, 0);
        dec_ready = 1'b1;
        pop_log.delete();
        n = 0;
        while (acc_cnt == 4 && n < 20) begin step(); n++; end
        chk("resume_addr", (acc_log.size() > 4) ? acc_log[4] : 32'hx, 32'h2000_0008);
        repeat (6) step();
        chk("drain_order0", (pop_log.size() > 0) ? pop_log[0] : 32'hx, START);
        chk("drain_order3", (pop_log.size() > 3) ? pop_log[3] : 32'hx, START + 32'd6);

        // Three-cycle memory with random request backpressure and decode stalls.
        lat = 3;
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            dec_ready = 1'($urandom_range(0, 1));
            step();
        end
        rand_ready = 0;
        mem_req_ready = 1'b1;
        dec_ready = 1'b1;

        // Redirect with two requests in flight and entries queued.
        dec_ready = 1'b0;
        n = 0;
        while (!(pend.size() == 2 && sb.size() >= 2) && n < 30) begin step(); n++; end
        chk("redirect_setup_count", queue_count >= 3'd2, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000_0100;
        dec_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk("flush_count", queue_count, 0);
        chk("flush_dec_valid", dec_valid, 0);
        chk("redirect_req_addr", mem_req_addr, 32'h2000_0100);
        pop_log.delete();
        repeat (12) step();
        chk("first_after_redirect", (pop_log.size() > 0) ? pop_log[0] : 32'hx, 32'h2000_0100);

        // Redirect in the same cycle as a response and a decode pop.
        lat = 2;
        n = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc && sb.size() > 0) && n < 30) begin
            step(); n++;
        end
        chk("coincident_setup", dec_valid, 1);
        a0 = pop_cnt;
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000_0200;
        step();
        redirect_valid = 1'b0;
        chk("coincident_no_pop", pop_cnt, a0);
        chk("coincident_flush", queue_count, 0);
        pop_log.delete();
        repeat (12) step();
        chk("coincident_first", (pop_log.size() > 0) ? pop_log[0] : 32'hx, 32'h2000_0200);

        // Back-to-back redirects; the last one wins and its address wraps.
        lat = 1;
        pop_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000_0000;
        step();
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("b2b_req_addr", mem_req_addr, 32'hFFFF_FFFE);
        repeat (8) step();
        chk("wrap_pop0", (pop_log.size() > 0) ? pop_log[0] : 32'hx, 32'hFFFF_FFFE);
        chk("wrap_pop1", (pop_log.size() > 1) ? pop_log[1] : 32'hx, 32'h0000_0000);

        // Reset in the middle of traffic clears everything in one cycle.
        dec_ready = 1'b0;
        repeat (3) step();
        do_reset();
        #1;
        chk("midrst_count", queue_count, 0);
        chk("midrst_req_addr", mem_req_addr, START);
        chk("midrst_req_valid", mem_req_valid, 1);
        dec_ready = 1'b1;
        repeat (6) step();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
